// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use bubble insertion, MEM-stage redirect
// squashing and a global memory-hold freeze.
module if_id_hazard_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      instr,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             hold_req,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             pc_write,
    output logic             ctrl_bubble,
    output logic             flush_ex,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HAZARD = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic redirect;
    logic raw_hazard;
    logic hazard_eff;

    assign redirect   = branch_taken | jump;
    assign raw_hazard = valid_q & idex_memread & (idex_rt != 5'd0) &
                        ((idex_rt == instr_q[25:21]) | (idex_rt == instr_q[20:16]));
    // Masking in HAZARD guarantees a single bubble per load even if ID/EX still shows it.
    assign hazard_eff = raw_hazard & ~redirect & (state_q != ST_HAZARD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every state applies the same priority order.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_HAZARD, ST_HOLD: begin
                if (hold_req)        state_d = ST_HOLD;
                else if (redirect)   state_d = ST_RUN;
                else if (hazard_eff) state_d = ST_HAZARD;
                else                 state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        pipe_hold   = hold_req;
        pc_write    = ~hold_req & ~hazard_eff;
        flush_ex    = ~hold_req & redirect;
        ctrl_bubble = ~hold_req & (redirect | hazard_eff);
        state       = state_q;
    end

    always_comb begin
        pc4_d       = pc4_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_req) begin
            pc4_d = pc4_q;
        end else if (redirect) begin
            pc4_d   = pc_plus4;
            instr_d = 32'd0;
            valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (hazard_eff) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            pc4_d   = pc_plus4;
            instr_d = instr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q       <= 32'd0;
            instr_q     <= 32'd0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ifid_pc4   = pc4_q;
    assign ifid_instr = instr_q;
    assign ifid_valid = valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
